arbitri_2ne1: RTL and testbench

ARBITRI_2NE1 -- requirements
Module: arbitri_2ne1

---
 rtl/arbitri_2ne1_pkg.sv | 13 +
 rtl/arbitri_2ne1_numruesi_mbajtjes.sv | 25 ++
 rtl/arbitri_2ne1.sv | 67 ++++++
 tb/tb_arbitri_2ne1.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/arbitri_2ne1_pkg.sv
// arbitri_2ne1_pkg: shared state encodings and default limits for the two-requester arbiter.
package arbitri_2ne1_pkg;

    typedef enum logic [1:0] {
        LIRE  = 2'b00,
        LEJE0 = 2'b01,
        LEJE1 = 2'b10
    } gjendja_t;

    localparam int MAX_MBAJTJE_DEF = 8;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/arbitri_2ne1_numruesi_mbajtjes.sv
// numruesi_mbajtjes: saturating hold counter with terminal count at MAX_MBAJTJE-1.
module numruesi_mbajtjes
    import arbitri_2ne1_pkg::*;
#(
    parameter int MAX_MBAJTJE = MAX_MBAJTJE_DEF
) (
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at all-ones so the count can never wrap back to zero.
    always_ff @(posedge i_clk) begin
        if (i_clear)
            r_cnt <= '0;
        else if (i_enable && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = r_cnt == CNT_W'(MAX_MBAJTJE - 1);

endmodule

// File: rtl/arbitri_2ne1.sv
// arbitri_2ne1: round-robin two-requester arbiter with hold timeout and registered grant/select outputs.
module arbitri_2ne1
    import arbitri_2ne1_pkg::*;
#(
    parameter int MAX_MBAJTJE = MAX_MBAJTJE_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Kerkesa0,
    input  logic Kerkesa1,
    input  logic Perfundo0,
    input  logic Perfundo1,
    output logic Leje0,
    output logic Leje1,
    output logic S,
    output logic Zene
);

    gjendja_t r_state;
    gjendja_t w_next;
    logic     r_prio;
    logic     w_tc;
    logic     w_rel;

    numruesi_mbajtjes #(.MAX_MBAJTJE(MAX_MBAJTJE)) u_numruesi (
        .i_clk    (Clock),
        .i_clear  (Reset || w_rel),
        .i_enable (r_state != LIRE),
        .o_tc     (w_tc)
    );

    // Done, dropped request and timeout all collapse into a single release.
    always_comb begin
        w_rel = (r_state == LEJE0 && (Perfundo0 || !Kerkesa0 || w_tc)) ||
                (r_state == LEJE1 && (Perfundo1 || !Kerkesa1 || w_tc));
        w_next = LIRE;
        case (r_state)
            LIRE:    w_next = (Kerkesa0 && Kerkesa1) ? (r_prio ? LEJE1 : LEJE0) :
                              Kerkesa0 ? LEJE0 : Kerkesa1 ? LEJE1 : LIRE;
            LEJE0:   w_next = !w_rel ? LEJE0 : Kerkesa1 ? LEJE1 : LIRE;
            LEJE1:   w_next = !w_rel ? LEJE1 : Kerkesa0 ? LEJE0 : LIRE;
            default: w_next = LIRE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= LIRE;
            r_prio  <= 1'b0;
            Leje0   <= 1'b0;
            Leje1   <= 1'b0;
            S       <= 1'b0;
            Zene    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_rel)
                r_prio <= r_state == LEJE0;
            Leje0 <= w_next == LEJE0;
            Leje1 <= w_next == LEJE1;
            Zene  <= w_next != LIRE;
            // S keeps its last granted value through idle so the mux never glitches.
            if (w_next != LIRE)
                S <= w_next == LEJE1;
        end
    end

endmodule

// File: tb/tb_arbitri_2ne1.sv
// tb_arbitri_2ne1: scoreboard bench comparing the arbiter against a behavioural ownership model.
module tb_arbitri_2ne1;

    localparam int MAX = 8;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic Kerkesa0 = 1'b0, Kerkesa1 = 1'b0, Perfundo0 = 1'b0, Perfundo1 = 1'b0;
    logic Leje0, Leje1, S, Zene;

    arbitri_2ne1 #(.MAX_MBAJTJE(MAX)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Kerkesa0  (Kerkesa0),
        .Kerkesa1  (Kerkesa1),
        .Perfundo0 (Perfundo0),
        .Perfundo1 (Perfundo1),
        .Leje0     (Leje0),
        .Leje1     (Leje1),
        .S         (S),
        .Zene      (Zene)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic l0;
        logic l1;
        logic s;
        logic z;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   done = 0;

    // Model: who owns the resource, how many cycles it has held it, and whose turn is next.
    int owner = -1;
    int held  = 0;
    int prio  = 0;
    bit s_last = 0;

    task automatic step(input bit r, input bit k0, input bit k1, input bit p0, input bit p1);
        bit req[2];
        bit fin[2];
        exp_t e;
        Reset = r; Kerkesa0 = k0; Kerkesa1 = k1; Perfundo0 = p0; Perfundo1 = p1;
        req[0] = k0; req[1] = k1; fin[0] = p0; fin[1] = p1;
        if (r) begin
            owner = -1; held = 0; prio = 0; s_last = 0;
        end else if (owner < 0) begin
            if (k0 && k1) owner = prio;
            else if (k0) owner = 0;
            else if (k1) owner = 1;
            held = (owner >= 0) ? 1 : 0;
        end else if (fin[owner] || !req[owner] || held == MAX) begin
            prio = 1 - owner;
            owner = req[1 - owner] ? 1 - owner : -1;
            held = (owner >= 0) ? 1 : 0;
        end else begin
            held++;
        end
        if (owner >= 0) s_last = (owner == 1);
        e.l0 = owner == 0;
        e.l1 = owner == 1;
        e.s  = s_last;
        e.z  = owner >= 0;
        q.push_back(e);
        @(posedge Clock);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({Leje0, Leje1, S, Zene} === e)
                    passed++;
                else
                    $display("FAIL outputs t=%0t got L0 L1 S Z=%b expected %b", $time,
                             {Leje0, Leje1, S, Zene}, e);
                checks++;
                if (!(Leje0 && Leje1))
                    passed++;
                else
                    $display("FAIL exclusive t=%0t got both grants high, expected at most one", $time);
            end
        end
    end

    initial begin : stimulus
        #2;
        // Reset held with both requests active.
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // Single request, then done pulse.
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Contention after reset, done hands over with no idle cycle.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // Timeout alternation.
        step(1, 0, 0, 0, 0);
        repeat (40) step(0, 1, 1, 0, 0);
        // Mid-grant reset during LEJE1, then both request.
        step(1, 1, 1, 0, 0);
        repeat (10) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0);
        // Stray release from non-owner.
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        repeat (4) step(0, 1, 1, 0, 0);
        // Randomized traffic with varying request density.
        for (int i = 0; i < 1500; i++) begin
            int dens;
            dens = ((i / 150) % 3 == 0) ? 2 : ((i / 150) % 3 == 1) ? 8 : 30;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, dens - 1) != 0,
                 $urandom_range(0, dens - 1) != 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 11) == 0);
        end
        step(0, 0, 0, 0, 0);
        repeat (3) @(posedge Clock);
        #3;
        checks++;
        if (q.size() == 0)
            passed++;
        else
            $display("FAIL drain got %0d pending expectations, expected 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
